// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with per-register busy scoreboard
//
// Purpose:
//   NUM_REG x WORD_SIZE register file with two combinational read ports and
//   one writeback port. Each register also carries a busy bit for in-order
//   issue. Issue reserves a destination through rsv_en/rsv_addr, which marks
//   it busy. Writeback writes the data and clears the busy bit. A flush
//   cancels every outstanding reservation. rsv_err is a sticky flag that
//   records a reservation made on a register that was already busy.
//
// Parameters:
//   WORD_SIZE - data width in bits
//   ADDR_W    - register address width, NUM_REG = 2**ADDR_W
//   BYPASS    - 1: a same-cycle write is forwarded to the reads (write-first)
//               0: reads return the pre-write value (read-first)
//   ZERO_R0   - 1: register 0 reads as zero and is never written or busy
//
// Ports:
//   clk                 in   sole clock, rising edge
//   reset               in   synchronous, active-high
//   rd_addr1/rd_addr2   in   read-port addresses
//   rd_data1/rd_data2   out  read data (combinational)
//   rd_busy1/rd_busy2   out  operand still pending (combinational)
//   wr_en/wr_addr/wr_data in writeback port
//   rsv_en/rsv_addr     in   destination reservation from issue
//   flush               in   cancel all reservations
//   busy_vec            out  registered busy bit per register
//   rsv_err             out  sticky double-reservation flag

module reg_file_sb #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_W    = 2,
  parameter int BYPASS    = 1,
  parameter int ZERO_R0   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        rd_addr1,
  input  logic [ADDR_W-1:0]        rd_addr2,
  output logic [WORD_SIZE-1:0]     rd_data1,
  output logic [WORD_SIZE-1:0]     rd_data2,
  output logic                     rd_busy1,
  output logic                     rd_busy2,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WORD_SIZE-1:0]     wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     flush,
  output logic [(2**ADDR_W)-1:0]   busy_vec,
  output logic                     rsv_err
);

  localparam int NUM_REG = 2 ** ADDR_W;

  logic [WORD_SIZE-1:0] regs_q [NUM_REG];
  logic [WORD_SIZE-1:0] regs_d [NUM_REG];
  logic [NUM_REG-1:0]   busy_q;
  logic [NUM_REG-1:0]   busy_d;
  logic                 rsv_err_q;
  logic                 rsv_err_d;

  // Effective write / reservation: with a hardwired r0, anything aimed at
  // register 0 is dropped here, so the rest of the logic never has to check.
  logic wr_ok;
  logic rsv_ok;
  logic wr_hits_rsv;

  always_comb begin
    wr_ok       = wr_en  && !((ZERO_R0 != 0) && (wr_addr  == '0));
    rsv_ok      = rsv_en && !((ZERO_R0 != 0) && (rsv_addr == '0));
    wr_hits_rsv = wr_ok && (wr_addr == rsv_addr);
  end

  // Data next state. Flush never touches data.
  always_comb begin
    regs_d = regs_q;
    if (wr_ok) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // Busy next state. The order matters: flush first, then writeback clear,
  // then the new reservation, so that a same-cycle reservation survives both
  // a flush and a writeback to the same register.
  always_comb begin
    busy_d = flush ? '0 : busy_q;
    if (wr_ok) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (rsv_ok) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  // A reservation on a busy register is an error unless the same edge's
  // writeback retires the previous producer of that register.
  always_comb begin
    rsv_err_d = rsv_err_q;
    if (rsv_ok && busy_q[rsv_addr] && !wr_hits_rsv) begin
      rsv_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q    <= '0;
      rsv_err_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      busy_q    <= busy_d;
      rsv_err_q <= rsv_err_d;
    end
  end

  // Read ports. Both ports share one decode so that equal addresses always
  // give identical data and busy values.
  logic [ADDR_W-1:0]    rd_addr [2];
  logic [WORD_SIZE-1:0] rd_data [2];
  logic                 rd_busy [2];

  always_comb begin
    rd_addr[0] = rd_addr1;
    rd_addr[1] = rd_addr2;
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = regs_q[rd_addr[p]];
      rd_busy[p] = busy_q[rd_addr[p]];
      if ((ZERO_R0 != 0) && (rd_addr[p] == '0)) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end else if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr[p])) begin
        // The value arriving this cycle is the one the operand waits on, so
        // it is no longer pending.
        rd_data[p] = wr_data;
        rd_busy[p] = 1'b0;
      end
    end
  end

  always_comb begin
    rd_data1 = rd_data[0];
    rd_data2 = rd_data[1];
    rd_busy1 = rd_busy[0];
    rd_busy2 = rd_busy[1];
    busy_vec = busy_q;
    rsv_err  = rsv_err_q;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - randomized and directed bench for reg_file_sb
//
// Three instances share one stimulus stream:
//   0: BYPASS=1 ZERO_R0=0   1: BYPASS=0 ZERO_R0=0   2: BYPASS=1 ZERO_R0=1

module tb_reg_file_sb;

  localparam int NC = 3;
  localparam int BYP [NC] = '{1, 0, 1};
  localparam int ZR  [NC] = '{0, 0, 1};

  logic        clk;
  logic        reset;
  logic [1:0]  rd_addr1, rd_addr2;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rsv_en;
  logic [1:0]  rsv_addr;
  logic        flush;

  logic [15:0] rd_data1 [NC];
  logic [15:0] rd_data2 [NC];
  logic        rd_busy1 [NC];
  logic        rd_busy2 [NC];
  logic [3:0]  busy_vec [NC];
  logic        rsv_err  [NC];

  reg_file_sb #(.WORD_SIZE(16), .ADDR_W(2), .BYPASS(1), .ZERO_R0(0)) u_c0 (
    .clk(clk), .reset(reset), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1[0]), .rd_data2(rd_data2[0]),
    .rd_busy1(rd_busy1[0]), .rd_busy2(rd_busy2[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush),
    .busy_vec(busy_vec[0]), .rsv_err(rsv_err[0]));

  reg_file_sb #(.WORD_SIZE(16), .ADDR_W(2), .BYPASS(0), .ZERO_R0(0)) u_c1 (
    .clk(clk), .reset(reset), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1[1]), .rd_data2(rd_data2[1]),
    .rd_busy1(rd_busy1[1]), .rd_busy2(rd_busy2[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush),
    .busy_vec(busy_vec[1]), .rsv_err(rsv_err[1]));

  reg_file_sb #(.WORD_SIZE(16), .ADDR_W(2), .BYPASS(1), .ZERO_R0(1)) u_c2 (
    .clk(clk), .reset(reset), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1[2]), .rd_data2(rd_data2[2]),
    .rd_busy1(rd_busy1[2]), .rd_busy2(rd_busy2[2]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush),
    .busy_vec(busy_vec[2]), .rsv_err(rsv_err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: architectural register contents, busy flags, error flag.
  logic [15:0] m_reg  [NC][4];
  bit          m_busy [NC][4];
  bit          m_err  [NC];

  function automatic logic [15:0] exp_data(int c, logic [1:0] a);
    if (ZR[c] != 0 && a == 2'd0) return 16'h0000;
    if (BYP[c] != 0 && wr_en && wr_addr == a) return wr_data;
    return m_reg[c][a];
  endfunction

  function automatic logic exp_busy(int c, logic [1:0] a);
    if (ZR[c] != 0 && a == 2'd0) return 1'b0;
    if (BYP[c] != 0 && wr_en && wr_addr == a) return 1'b0;
    return m_busy[c][a];
  endfunction

  function automatic logic [3:0] exp_vec(int c);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_busy[c][i];
    return v;
  endfunction

  task automatic compare_all();
    for (int c = 0; c < NC; c++) begin
      check($sformatf("c%0d rd_data1", c), {16'h0, rd_data1[c]}, {16'h0, exp_data(c, rd_addr1)});
      check($sformatf("c%0d rd_data2", c), {16'h0, rd_data2[c]}, {16'h0, exp_data(c, rd_addr2)});
      check($sformatf("c%0d rd_busy1", c), {31'h0, rd_busy1[c]}, {31'h0, exp_busy(c, rd_addr1)});
      check($sformatf("c%0d rd_busy2", c), {31'h0, rd_busy2[c]}, {31'h0, exp_busy(c, rd_addr2)});
      check($sformatf("c%0d busy_vec", c), {28'h0, busy_vec[c]}, {28'h0, exp_vec(c)});
      check($sformatf("c%0d rsv_err", c),  {31'h0, rsv_err[c]},  {31'h0, m_err[c]});
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NC; c++) begin
      for (int i = 0; i < 4; i++) begin
        m_reg[c][i]  = 16'h0;
        m_busy[c][i] = 1'b0;
      end
      m_err[c] = 1'b0;
    end
  endtask

  // Edge semantics written straight from the rules: reset wins; otherwise a
  // reservation on a busy register is an error unless the same edge writes it
  // back; data is written; busy = flushed-or-kept, cleared by writeback,
  // then set by the new reservation.
  task automatic model_step();
    if (reset) begin
      model_clear();
      return;
    end
    for (int c = 0; c < NC; c++) begin
      bit wok, rok;
      wok = wr_en  && !(ZR[c] != 0 && wr_addr  == 2'd0);
      rok = rsv_en && !(ZR[c] != 0 && rsv_addr == 2'd0);
      if (rok && m_busy[c][rsv_addr] && !(wok && wr_addr == rsv_addr)) m_err[c] = 1'b1;
      if (wok) m_reg[c][wr_addr] = wr_data;
      if (flush) for (int i = 0; i < 4; i++) m_busy[c][i] = 1'b0;
      if (wok) m_busy[c][wr_addr] = 1'b0;
      if (rok) m_busy[c][rsv_addr] = 1'b1;
    end
  endtask

  task automatic drive(input bit rst, input bit we, input logic [1:0] wa, input logic [15:0] wd,
                       input bit re, input logic [1:0] ra, input bit fl,
                       input logic [1:0] a1, input logic [1:0] a2);
    reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
    rsv_en = re; rsv_addr = ra; flush = fl;
    rd_addr1 = a1; rd_addr2 = a2;
    #1;
    compare_all();
  endtask

  task automatic idle(input logic [1:0] a1, input logic [1:0] a2);
    drive(0, 0, 2'd0, 16'h0, 0, 2'd0, 0, a1, a2);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 16'h0;
    rsv_en = 1'b0; rsv_addr = 2'd0; flush = 1'b0; rd_addr1 = 2'd0; rd_addr2 = 2'd0;
    repeat (2) @(posedge clk);
    model_clear();
    @(negedge clk);

    // Reset state on every address.
    for (int a = 0; a < 4; a++) begin
      idle(a[1:0], a[1:0]);
      check("rst rd_data1", {16'h0, rd_data1[0]}, 32'h0);
    end
    check("rst busy_vec", {28'h0, busy_vec[0]}, 32'h0);
    check("rst rsv_err", {31'h0, rsv_err[0]}, 32'h0);
    tick();

    // Write r2, read it the next cycle.
    drive(0, 1, 2'd2, 16'h1234, 0, 2'd0, 0, 2'd0, 2'd0);
    tick();
    idle(2'd2, 2'd0);
    check("wr r2 data", {16'h0, rd_data1[0]}, 32'h1234);
    check("wr r2 busy", {31'h0, rd_busy1[0]}, 32'h0);
    tick();

    // Same-cycle forwarding vs read-first.
    drive(0, 1, 2'd1, 16'hBEEF, 0, 2'd0, 0, 2'd0, 2'd1);
    check("bypass data", {16'h0, rd_data2[0]}, 32'hBEEF);
    check("bypass busy", {31'h0, rd_busy2[0]}, 32'h0);
    check("readfirst data", {16'h0, rd_data2[1]}, 32'h0000);
    tick();

    // Reservation, then reservation plus writeback on the same register.
    drive(0, 0, 2'd0, 16'h0, 1, 2'd3, 0, 2'd0, 2'd0);
    tick();
    idle(2'd3, 2'd0);
    check("rsv r3 vec", {28'h0, busy_vec[0]}, 32'h8);
    check("rsv r3 busy", {31'h0, rd_busy1[0]}, 32'h1);
    tick();
    drive(0, 1, 2'd3, 16'h0055, 1, 2'd3, 0, 2'd0, 2'd0);
    tick();
    idle(2'd3, 2'd3);
    check("rsv+wr vec", {28'h0, busy_vec[0]}, 32'h8);
    check("rsv+wr data", {16'h0, rd_data1[0]}, 32'h0055);
    check("rsv+wr err", {31'h0, rsv_err[0]}, 32'h0);
    tick();

    // Double reservation sets sticky error, cleared only by reset.
    drive(0, 0, 2'd0, 16'h0, 1, 2'd1, 0, 2'd0, 2'd0);
    tick();
    drive(0, 0, 2'd0, 16'h0, 1, 2'd1, 0, 2'd0, 2'd0);
    tick();
    idle(2'd1, 2'd0);
    check("dbl rsv err", {31'h0, rsv_err[0]}, 32'h1);
    tick();
    drive(0, 1, 2'd1, 16'h0001, 0, 2'd0, 1, 2'd0, 2'd0);
    tick();
    idle(2'd0, 2'd0);
    check("err sticky", {31'h0, rsv_err[0]}, 32'h1);
    drive(1, 0, 2'd0, 16'h0, 0, 2'd0, 0, 2'd0, 2'd0);
    tick();
    idle(2'd0, 2'd0);
    check("err reset", {31'h0, rsv_err[0]}, 32'h0);
    tick();

    // Flush with a same-cycle reservation of r0.
    drive(0, 1, 2'd1, 16'h1111, 0, 2'd0, 0, 2'd0, 2'd0);
    tick();
    drive(0, 1, 2'd2, 16'h2222, 1, 2'd1, 0, 2'd0, 2'd0);
    tick();
    drive(0, 0, 2'd0, 16'h0, 1, 2'd2, 0, 2'd0, 2'd0);
    tick();
    drive(0, 0, 2'd0, 16'h0, 1, 2'd0, 1, 2'd0, 2'd0);
    tick();
    idle(2'd1, 2'd2);
    check("flush vec", {28'h0, busy_vec[0]}, 32'h1);
    check("flush r1", {16'h0, rd_data1[0]}, 32'h1111);
    check("flush r2", {16'h0, rd_data2[0]}, 32'h2222);
    check("flush z vec", {28'h0, busy_vec[2]}, 32'h0);
    tick();
    drive(0, 1, 2'd0, 16'hFFFF, 0, 2'd0, 0, 2'd0, 2'd0);
    check("z r0 nofwd", {16'h0, rd_data1[2]}, 32'h0);
    tick();
    idle(2'd0, 2'd0);
    check("z r0 read", {16'h0, rd_data1[2]}, 32'h0);
    check("r0 read", {16'h0, rd_data1[0]}, 32'hFFFF);
    tick();

    // Reset wins over a same-cycle write and reservation.
    drive(1, 1, 2'd2, 16'h7777, 1, 2'd2, 0, 2'd0, 2'd0);
    tick();
    idle(2'd2, 2'd0);
    check("rstpri data", {16'h0, rd_data1[0]}, 32'h0);
    check("rstpri vec", {28'h0, busy_vec[0]}, 32'h0);
    check("rstpri err", {31'h0, rsv_err[0]}, 32'h0);
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      drive($urandom_range(0, 39) == 0,
            $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 16'($urandom),
            $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
            $urandom_range(0, 9) == 0,
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 2, register address width; NUM_REG = 2**ADDR_W.
REQ-003 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding.
REQ-004 SHALL have parameter ZERO_R0, default 0, 1 = register 0 is hardwired zero.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high.
REQ-007 SHALL have ports rd_addr1 / rd_addr2, input, ADDR_W, read-port addresses.
REQ-008 SHALL have ports rd_data1 / rd_data2, output, WORD_SIZE, read data (combinational).
REQ-009 SHALL have ports rd_busy1 / rd_busy2, output, 1, operand still pending (combinational).
REQ-010 SHALL have ports wr_en (1), wr_addr (ADDR_W) and wr_data (WORD_SIZE), inputs, writeback port.
REQ-011 SHALL have ports rsv_en (1) and rsv_addr (ADDR_W), inputs, destination reservation from issue.
REQ-012 SHALL have port flush, input, 1, cancel all reservations.
REQ-013 SHALL have port busy_vec, output, NUM_REG, registered busy bit per register.
REQ-014 SHALL have port rsv_err, output, 1, sticky flag: reservation made on an already-busy register.

Function
REQ-015 SHALL hold NUM_REG x WORD_SIZE data registers and NUM_REG busy bits.
REQ-016 SHALL, on a clock edge with wr_en=1, set reg[wr_addr] <= wr_data.
REQ-017 SHALL drive rd_dataN = reg[rd_addrN] combinationally, with zero added latency.
REQ-018 SHALL, when BYPASS=1 and wr_en=1 and wr_addr==rd_addrN, drive rd_dataN = wr_data in the same cycle (write-first).
REQ-019 SHALL, when BYPASS=0, return the pre-write value in the write cycle (read-first).
REQ-020 SHALL, on a clock edge with rsv_en=1, set busy[rsv_addr] <= 1.
REQ-021 SHALL, on a clock edge with wr_en=1, clear busy[wr_addr] <= 0.
REQ-022 SHALL, when rsv_en and wr_en target the same address in one cycle, leave busy set, because the new reservation takes priority over the writeback clear; data is still written.
REQ-023 SHALL, on a clock edge with flush=1, clear all busy bits except the one set by a same-cycle rsv_en, which ends set.
REQ-024 SHALL keep register data unchanged on flush.
REQ-025 SHALL drive rd_busyN = busy[rd_addrN], masked to 0 when BYPASS=1 and a same-cycle wr_en targets rd_addrN.
REQ-026 SHALL set rsv_err <= 1 on an edge where rsv_en=1 and busy[rsv_addr]=1 and no same-cycle write clears that bit; rsv_err stays set until reset.
REQ-027 SHALL, when ZERO_R0=1, read register 0 as 0, ignore writes to it, never set busy[0], never forward to it, and never raise rsv_err for it.
REQ-028 SHALL, when both read ports address the same register, return identical data and busy values on both.
REQ-029 SHALL accept wr_en without a prior reservation, writing data and leaving busy clear.

Reset
REQ-030 SHALL, on a clock edge with reset=1, clear all data registers to 0, all busy bits to 0 and rsv_err to 0.
REQ-031 SHALL give reset priority over wr_en, rsv_en and flush in the same cycle.
REQ-032 SHALL, from the first edge after reset is deasserted, show busy_vec=0, rsv_err=0 and rd_dataN=0 for all addresses, until the first write or reservation.

Verification
REQ-033 SHALL check: reset; write r2=16'h1234; next cycle read rd_addr1=2 -> rd_data1=16'h1234, rd_busy1=0.
REQ-034 SHALL check: BYPASS=1, wr_en r1=16'hBEEF with rd_addr2=1 in the same cycle -> rd_data2=16'hBEEF and rd_busy2=0 that cycle; BYPASS=0 -> old value 16'h0000.
REQ-035 SHALL check: rsv r3 -> busy_vec=4'b1000 and rd_busy for r3=1; then rsv r3 and wr r3=16'h0055 in the same cycle -> busy stays 1, reg3=16'h0055, rsv_err=0.
REQ-036 SHALL check: rsv r1 then rsv r1 again with no write -> rsv_err=1 after the second edge; it persists until reset, then reads 0.
REQ-037 SHALL check: busy r1 and r2, then flush with rsv r0 in the same cycle (ZERO_R0=0) -> busy_vec=4'b0001 and data unchanged; with ZERO_R0=1 -> busy_vec=0 and r0 reads 0 after a write of 16'hFFFF.
REQ-038 SHALL check: reset asserted in a cycle with wr_en r2=16'h7777 and rsv_en r2 -> next cycle r2=0, busy_vec=0, rsv_err=0.
